// File: rtl/alien_pixel_painter_if.sv
// Request/pixel bundle between a game controller and the alien row painter.
interface alien_pixel_painter_if;
    logic       kill1, kill2, kill3, kill4, kill5;
    logic       moveDown;
    logic [7:0] alienTopX, alienBottomX;
    logic [6:0] alienTopY, alienBottomY;
    logic [7:0] vgaX;
    logic [6:0] vgaY;
    logic [2:0] vgaColour;
    logic       plot;
    logic       cleared1, cleared2, cleared3, cleared4, cleared5;
    logic       clearedShift;
    logic       busy;

    modport master (
        output kill1, kill2, kill3, kill4, kill5, moveDown,
        output alienTopX, alienBottomX, alienTopY, alienBottomY,
        input  vgaX, vgaY, vgaColour, plot,
        input  cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift, busy
    );

    modport slave (
        input  kill1, kill2, kill3, kill4, kill5, moveDown,
        input  alienTopX, alienBottomX, alienTopY, alienBottomY,
        output vgaX, vgaY, vgaColour, plot,
        output cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift, busy
    );
endinterface

// File: rtl/alien_pixel_painter.sv
// Paints a row of five aliens one pixel per clock: initial draw, per-alien
// rectangle erase and one-pixel downward row shifts.
module alien_pixel_painter #(
    parameter logic [7:0] width       = 8'd12,
    parameter logic [6:0] height      = 7'd10,
    parameter logic [7:0] gap         = 8'd20,
    parameter logic [7:0] startX      = 8'd10,
    parameter logic [6:0] startY      = 7'd10,
    parameter logic [2:0] alienColour = 3'b010,
    parameter logic [2:0] bgColour    = 3'b000
) (
    input logic                  clk,
    input logic                  reset,
    alien_pixel_painter_if.slave bus
);
    localparam logic [6:0] ROW_Y_MAX = 7'd119;
    localparam logic [2:0] LAST_COL  = 3'd4;

    typedef enum logic [2:0] {
        INIT_DRAW,
        IDLE,
        ERASE,
        KILL_DONE,
        SHIFT_ERASE,
        SHIFT_DRAW,
        SHIFT_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] row_y_q, row_y_d;
    logic [4:0] alive_q, alive_d;
    logic [2:0] col_q, col_d;
    logic [7:0] xo_q, xo_d;
    logic [6:0] yo_q, yo_d;
    logic [7:0] px_q, px_d;
    logic [6:0] py_q, py_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;
    logic [2:0] kidx_q, kidx_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       plot_q, plot_d;
    logic [4:0] cleared_q, cleared_d;
    logic       cleared_shift_q, cleared_shift_d;
    logic       busy_q, busy_d;

    logic [4:0] kill_vec;
    logic [2:0] kill_sel;
    logic [8:0] col_x;
    logic [7:0] draw_y;
    logic       xo_last, yo_last, col_last, px_last, py_last, bounds_bad;

    assign kill_vec   = {bus.kill5, bus.kill4, bus.kill3, bus.kill2, bus.kill1};
    assign col_x      = {1'b0, startX} + 9'(col_q) * ({1'b0, width} + {1'b0, gap}) + {1'b0, xo_q};
    assign draw_y     = {1'b0, row_y_q} + {1'b0, height} + 8'd1;
    assign xo_last    = (xo_q == width);
    assign yo_last    = (yo_q == height);
    assign col_last   = (col_q == LAST_COL);
    assign px_last    = (px_q == bx_q);
    assign py_last    = (py_q == by_q);
    assign bounds_bad = (bus.alienBottomX < bus.alienTopX) || (bus.alienBottomY < bus.alienTopY);

    // Lowest-numbered kill wins when several arrive together.
    always_comb begin
        kill_sel = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (kill_vec[i]) kill_sel = 3'(i);
        end
    end

    always_comb begin
        state_d         = state_q;
        row_y_d         = row_y_q;
        alive_d         = alive_q;
        col_d           = col_q;
        xo_d            = xo_q;
        yo_d            = yo_q;
        px_d            = px_q;
        py_d            = py_q;
        tx_d            = tx_q;
        bx_d            = bx_q;
        by_d            = by_q;
        kidx_d          = kidx_q;
        vga_x_d         = vga_x_q;
        vga_y_d         = vga_y_q;
        vga_colour_d    = vga_colour_q;
        plot_d          = 1'b0;
        cleared_d       = 5'd0;
        cleared_shift_d = 1'b0;

        case (state_q)
            INIT_DRAW: begin
                plot_d       = 1'b1;
                vga_x_d      = col_x[7:0];
                vga_y_d      = row_y_q + yo_q;
                vga_colour_d = alienColour;
                if (!xo_last) begin
                    xo_d = xo_q + 8'd1;
                end else begin
                    xo_d = 8'd0;
                    if (!yo_last) begin
                        yo_d = yo_q + 7'd1;
                    end else begin
                        yo_d = 7'd0;
                        if (!col_last) begin
                            col_d = col_q + 3'd1;
                        end else begin
                            col_d   = 3'd0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            IDLE: begin
                // busy_q still high means the last pixel/pulse is on the outputs.
                if (!busy_q) begin
                    if (|kill_vec) begin
                        kidx_d  = kill_sel;
                        tx_d    = bus.alienTopX;
                        bx_d    = bus.alienBottomX;
                        by_d    = bus.alienBottomY;
                        px_d    = bus.alienTopX;
                        py_d    = bus.alienTopY;
                        state_d = bounds_bad ? KILL_DONE : ERASE;
                    end else if (bus.moveDown) begin
                        col_d   = 3'd0;
                        xo_d    = 8'd0;
                        state_d = SHIFT_ERASE;
                    end
                end
            end
            ERASE: begin
                plot_d       = 1'b1;
                vga_x_d      = px_q;
                vga_y_d      = py_q;
                vga_colour_d = bgColour;
                if (!px_last) begin
                    px_d = px_q + 8'd1;
                end else begin
                    px_d = tx_q;
                    if (!py_last) py_d = py_q + 7'd1;
                    else          state_d = KILL_DONE;
                end
            end
            KILL_DONE: begin
                cleared_d[kidx_q] = 1'b1;
                alive_d[kidx_q]   = 1'b0;
                state_d           = IDLE;
            end
            SHIFT_ERASE: begin
                plot_d       = alive_q[col_q];
                vga_x_d      = col_x[7:0];
                vga_y_d      = row_y_q;
                vga_colour_d = bgColour;
                if (!xo_last) begin
                    xo_d = xo_q + 8'd1;
                end else begin
                    xo_d = 8'd0;
                    if (!col_last) begin
                        col_d = col_q + 3'd1;
                    end else begin
                        col_d   = 3'd0;
                        state_d = SHIFT_DRAW;
                    end
                end
            end
            SHIFT_DRAW: begin
                plot_d       = alive_q[col_q] && (draw_y <= {1'b0, ROW_Y_MAX});
                vga_x_d      = col_x[7:0];
                vga_y_d      = draw_y[6:0];
                vga_colour_d = alienColour;
                if (!xo_last) begin
                    xo_d = xo_q + 8'd1;
                end else begin
                    xo_d = 8'd0;
                    if (!col_last) begin
                        col_d = col_q + 3'd1;
                    end else begin
                        col_d   = 3'd0;
                        state_d = SHIFT_DONE;
                    end
                end
            end
            SHIFT_DONE: begin
                cleared_shift_d = 1'b1;
                if (row_y_q < ROW_Y_MAX) row_y_d = row_y_q + 7'd1;
                state_d = IDLE;
            end
            default: state_d = INIT_DRAW;
        endcase

        busy_d = (state_d != IDLE) || (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= INIT_DRAW;
            row_y_q         <= startY;
            alive_q         <= 5'b11111;
            col_q           <= 3'd0;
            xo_q            <= 8'd0;
            yo_q            <= 7'd0;
            px_q            <= 8'd0;
            py_q            <= 7'd0;
            tx_q            <= 8'd0;
            bx_q            <= 8'd0;
            by_q            <= 7'd0;
            kidx_q          <= 3'd0;
            vga_x_q         <= 8'd0;
            vga_y_q         <= 7'd0;
            vga_colour_q    <= 3'd0;
            plot_q          <= 1'b0;
            cleared_q       <= 5'd0;
            cleared_shift_q <= 1'b0;
            busy_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            row_y_q         <= row_y_d;
            alive_q         <= alive_d;
            col_q           <= col_d;
            xo_q            <= xo_d;
            yo_q            <= yo_d;
            px_q            <= px_d;
            py_q            <= py_d;
            tx_q            <= tx_d;
            bx_q            <= bx_d;
            by_q            <= by_d;
            kidx_q          <= kidx_d;
            vga_x_q         <= vga_x_d;
            vga_y_q         <= vga_y_d;
            vga_colour_q    <= vga_colour_d;
            plot_q          <= plot_d;
            cleared_q       <= cleared_d;
            cleared_shift_q <= cleared_shift_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.vgaX         = vga_x_q;
    assign bus.vgaY         = vga_y_q;
    assign bus.vgaColour    = vga_colour_q;
    assign bus.plot         = plot_q;
    assign bus.cleared1     = cleared_q[0];
    assign bus.cleared2     = cleared_q[1];
    assign bus.cleared3     = cleared_q[2];
    assign bus.cleared4     = cleared_q[3];
    assign bus.cleared5     = cleared_q[4];
    assign bus.clearedShift = cleared_shift_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_alien_pixel_painter.sv
// Scoreboard bench for the alien row painter: a geometric model queues every
// expected pixel and done pulse; a negedge monitor pops and compares.
module tb_alien_pixel_painter;
    logic clk;
    logic rst;

    alien_pixel_painter_if bus ();

    alien_pixel_painter dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    typedef struct {
        int kind;     // 0 pixel, 1..5 clearedN, 6 clearedShift
        int x;
        int y;
        int c;
        int exp_cyc;  // -1 unchecked, -2 one cycle after last plot, else absolute cycle
    } ev_t;

    ev_t  sb[$];
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   last_plot;
    bit   alive_m[5];
    int   row_m;

    ev_t        mon_e;
    logic [5:0] got_ev;
    logic [5:0] exp_ev;
    int         tgt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void push_px(int x, int y, int c);
        ev_t e;
        e.kind = 0; e.x = x; e.y = y; e.c = c; e.exp_cyc = -1;
        sb.push_back(e);
    endfunction

    function automatic void push_ev(int k, int ec);
        ev_t e;
        e.kind = k; e.x = 0; e.y = 0; e.c = 0; e.exp_cyc = ec;
        sb.push_back(e);
    endfunction

    function automatic int col_left(int i);
        return (10 + i * 32) % 256;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) alive_m[i] = 1'b1;
        row_m = 10;
        for (int i = 0; i < 5; i++)
            for (int y = row_m; y <= row_m + 10; y++)
                for (int x = col_left(i); x <= col_left(i) + 12; x++)
                    push_px(x, y, 2);
    endfunction

    function automatic void model_kill(int n, int tx, int bx, int ty, int by, int req_cyc);
        if (bx < tx || by < ty) begin
            push_ev(n, req_cyc + 2);
        end else begin
            for (int y = ty; y <= by; y++)
                for (int x = tx; x <= bx; x++)
                    push_px(x, y, 0);
            push_ev(n, -2);
        end
        alive_m[n-1] = 1'b0;
    endfunction

    function automatic void model_shift();
        for (int i = 0; i < 5; i++)
            for (int x = col_left(i); x <= col_left(i) + 12; x++)
                if (alive_m[i]) push_px(x, row_m, 0);
        for (int i = 0; i < 5; i++)
            for (int x = col_left(i); x <= col_left(i) + 12; x++)
                if (alive_m[i] && row_m + 11 <= 119) push_px(x, row_m + 11, 2);
        push_ev(6, -1);
        if (row_m < 119) row_m++;
    endfunction

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic chk(string nm, int got, int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (bus.busy !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: busy=%b, required 0", bus.busy);
            finish_run();
        end
        chk("drain_pending_events", sb.size(), 0);
        sb.delete();
    endtask

    task automatic issue(logic [4:0] kv, logic mv, int tx, int bx, int ty, int by);
        int n;
        wait_idle();
        bus.alienTopX    = 8'(tx);
        bus.alienBottomX = 8'(bx);
        bus.alienTopY    = 7'(ty);
        bus.alienBottomY = 7'(by);
        bus.kill1 = kv[0]; bus.kill2 = kv[1]; bus.kill3 = kv[2];
        bus.kill4 = kv[3]; bus.kill5 = kv[4];
        bus.moveDown = mv;
        if (kv != 5'd0) begin
            n = 0;
            for (int i = 4; i >= 0; i--) if (kv[i]) n = i;
            model_kill(n + 1, tx, bx, ty, by, cyc);
        end else if (mv) begin
            model_shift();
        end
        @(posedge clk); #1;
        bus.kill1 = 1'b0; bus.kill2 = 1'b0; bus.kill3 = 1'b0;
        bus.kill4 = 1'b0; bus.kill5 = 1'b0; bus.moveDown = 1'b0;
    endtask

    // Monitor: every plot or done pulse must match the head of the scoreboard.
    initial begin
        last_plot = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.plot === 1'b1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL pixel: unexpected plot at (%0d,%0d) colour %0d, required no plot",
                                 bus.vgaX, bus.vgaY, bus.vgaColour);
                    end else if (sb[0].kind != 0) begin
                        n_bad++;
                        $display("FAIL pixel: plot at (%0d,%0d), required done pulse kind %0d",
                                 bus.vgaX, bus.vgaY, sb[0].kind);
                    end else begin
                        mon_e = sb.pop_front();
                        if (int'(bus.vgaX) != mon_e.x || int'(bus.vgaY) != mon_e.y ||
                            int'(bus.vgaColour) != mon_e.c) begin
                            n_bad++;
                            $display("FAIL pixel: got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                                     bus.vgaX, bus.vgaY, bus.vgaColour, mon_e.x, mon_e.y, mon_e.c);
                        end
                    end
                    last_plot = cyc;
                end
                got_ev = {bus.clearedShift, bus.cleared5, bus.cleared4,
                          bus.cleared3, bus.cleared2, bus.cleared1};
                if (got_ev != 6'd0) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL done_pulse: got pulses %b, required none", got_ev);
                    end else if (sb[0].kind == 0) begin
                        n_bad++;
                        $display("FAIL done_pulse: got pulses %b, required pixel (%0d,%0d)",
                                 got_ev, sb[0].x, sb[0].y);
                    end else begin
                        mon_e  = sb.pop_front();
                        exp_ev = (mon_e.kind == 6) ? 6'b100000 : 6'(1 << (mon_e.kind - 1));
                        if (got_ev != exp_ev) begin
                            n_bad++;
                            $display("FAIL done_pulse: got pulses %b, required %b", got_ev, exp_ev);
                        end
                        if (mon_e.exp_cyc != -1) begin
                            tgt = (mon_e.exp_cyc == -2) ? last_plot + 1 : mon_e.exp_cyc;
                            n_cmp++;
                            if (cyc != tgt) begin
                                n_bad++;
                                $display("FAIL done_timing: pulse at cycle %0d, required cycle %0d", cyc, tgt);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int r, tx, bx, ty, by;
        logic [4:0] kv;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.kill1 = 1'b0; bus.kill2 = 1'b0; bus.kill3 = 1'b0;
        bus.kill4 = 1'b0; bus.kill5 = 1'b0; bus.moveDown = 1'b0;
        bus.alienTopX = 8'd0; bus.alienBottomX = 8'd0;
        bus.alienTopY = 7'd0; bus.alienBottomY = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_plot", int'(bus.plot), 0);
        chk("reset_busy", int'(bus.busy), 1);
        chk("reset_vgaX", int'(bus.vgaX), 0);
        chk("reset_vgaY", int'(bus.vgaY), 0);
        chk("reset_colour", int'(bus.vgaColour), 0);
        chk("reset_cleared", int'({bus.cleared5, bus.cleared4, bus.cleared3, bus.cleared2, bus.cleared1}), 0);
        chk("reset_clearedShift", int'(bus.clearedShift), 0);

        model_reset();
        rst = 1'b0;

        issue(5'b00100, 1'b0, 74, 86, 10, 20);
        issue(5'b00000, 1'b1, 0, 0, 0, 0);
        issue(5'b00000, 1'b1, 0, 0, 0, 0);

        issue(5'b00010, 1'b1, 42, 54, 12, 22);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_during_erase", int'(bus.busy), 1);
        bus.kill4 = 1'b1;
        @(posedge clk); #1;
        bus.kill4 = 1'b0;

        issue(5'b00001, 1'b0, 20, 10, 10, 20);
        issue(5'b00000, 1'b1, 0, 0, 0, 0);

        for (int it = 0; it < 30; it++) begin
            r  = int'($urandom_range(0, 9));
            tx = int'($urandom_range(0, 230));
            bx = tx + int'($urandom_range(0, 12));
            ty = int'($urandom_range(0, 105));
            by = ty + int'($urandom_range(0, 10));
            kv = 5'(1 << $urandom_range(0, 4));
            case (r)
                5, 6: issue(5'b00000, 1'b1, tx, bx, ty, by);
                7:    issue(kv, 1'b1, tx, bx, ty, by);
                8:    issue(kv | 5'($urandom_range(1, 31)), 1'b0, tx, bx, ty, by);
                9:    issue(kv, 1'b0, tx + 5, tx, ty, by);
                default: issue(kv, 1'b0, tx, bx, ty, by);
            endcase
        end

        issue(5'b10000, 1'b0, 138, 150, 13, 23);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_plot", int'(bus.plot), 0);
        chk("midreset_cleared", int'({bus.clearedShift, bus.cleared5, bus.cleared4,
                                      bus.cleared3, bus.cleared2, bus.cleared1}), 0);
        chk("midreset_busy", int'(bus.busy), 1);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        issue(5'b00001, 1'b0, 10, 22, 10, 20);
        issue(5'b00000, 1'b1, 0, 0, 0, 0);
        wait_idle();
        finish_run();
    end
endmodule

// File: doc/alien_pixel_painter.md
ALIEN_PIXEL_PAINTER -- requirements
Module: alien_pixel_painter

Interface
REQ-001 SHALL have parameters: width 8'd12 (alien x-extent); height 7'd10 (alien y-extent); gap 8'd20 (column spacing); startX 8'd10 (column-0 left x); startY 7'd10 (initial row top y); alienColour 3'b010 (draw colour); bgColour 3'b000 (erase colour).
REQ-002 SHALL have ports:
- clk  in  1  system clock; one clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high
- kill1..kill5  in  1 each  erase request, alien N
- moveDown  in  1  shift-row request
- alienTopX, alienBottomX  in  8 each  kill rectangle x bounds, inclusive
- alienTopY, alienBottomY  in  7 each  kill rectangle y bounds, inclusive
- vgaX  out  8  pixel x
- vgaY  out  7  pixel y
- vgaColour  out  3  pixel colour
- plot  out  1  pixel write strobe
- cleared1..cleared5  out  1 each  kill-N done pulse
- clearedShift  out  1  shift done pulse
- busy  out  1  high while not IDLE

Function
REQ-003 SHALL implement states INIT_DRAW, IDLE, ERASE, KILL_DONE, SHIFT_ERASE, SHIFT_DRAW, SHIFT_DONE; registered outputs.
REQ-004 Column i (0..4) SHALL span x = startX + i*(width+gap) .. that + width inclusive (13 px); 9-bit intermediate arithmetic, truncated to 8 bits.
REQ-005 Internal rowY (7 bits) SHALL hold the current row top; internal alive[4:0] SHALL track living aliens.
REQ-006 INIT_DRAW SHALL raster all 5 columns, y = rowY..rowY+height, x inner loop, column outermost; one pixel/cycle, plot=1, colour alienColour; 715 cycles; then IDLE.
REQ-007 In IDLE, a kill pulse SHALL latch the index and all four bounds in that cycle and enter ERASE; multiple kills in one cycle: lowest index wins, others dropped.
REQ-008 ERASE SHALL raster the latched rectangle (x inner, y outer) with plot=1, colour bgColour, one pixel/cycle; latency (bx-tx+1)*(by-ty+1) cycles.
REQ-009 If alienBottomX < alienTopX or alienBottomY < alienTopY, ERASE SHALL plot nothing and go directly to KILL_DONE.
REQ-010 KILL_DONE SHALL assert clearedN for exactly one cycle, clear alive[N-1], return to IDLE; a kill of an already-dead alien still erases and pulses.
REQ-011 In IDLE with moveDown and no kill, SHALL enter SHIFT_ERASE; kill has priority on simultaneous assertion and moveDown is dropped.
REQ-012 SHIFT_ERASE SHALL step all 5 columns x 13 px on y=rowY (65 cycles), plot=1 only in alive columns, colour bgColour.
REQ-013 SHIFT_DRAW SHALL step likewise on y=rowY+height+1 (65 cycles), colour alienColour.
REQ-014 SHIFT_DONE SHALL pulse clearedShift one cycle, increment rowY, return to IDLE; rowY saturates at 7'd119 (no further shift drawing beyond y=119, pulse still issued).
REQ-015 kill/moveDown while busy=1 SHALL be ignored; no queuing.
REQ-016 vgaX/vgaY/vgaColour SHALL be valid in every cycle plot=1; plot=0 in IDLE, KILL_DONE, SHIFT_DONE.

Reset
REQ-017 On reset: state INIT_DRAW, rowY=startY, alive=5'b11111, all outputs 0 (busy=1), scan counters at column 0 origin.
REQ-018 Reset asserted mid-operation SHALL abort immediately, no done pulse; painting restarts with INIT_DRAW on release.

Verification
REQ-019 Release reset -> 715 plot cycles colour 3'b010, first (10,10), last (150,20), then busy=0.
REQ-020 kill3 with bounds (74,10)-(86,20) -> 143 plot cycles colour 3'b000, first (74,10), last (86,20), cleared3 high exactly one cycle after last pixel.
REQ-021 Then moveDown -> 130 cycles; 52 plots at y=10 colour 0, 52 plots at y=21 colour 3'b010, none in x=74..86; clearedShift pulse; second moveDown uses y=11 and y=22.
REQ-022 kill2 and moveDown same cycle -> only cleared2 pulses; kill4 during that erase -> ignored, no cleared4.
REQ-023 kill1 with bounds (20,10)-(10,20) -> zero plots, cleared1 two cycles after request.
REQ-024 reset asserted mid-ERASE -> plot=0 and cleared*=0 immediately; INIT_DRAW restarts at (10,10) after release.
